// File: rtl/rep_flags_seq_wb_pkg.sv
// Shared definitions for the REP/REPE/REPNE writeback sequencer and EFLAGS register.
package rep_flags_seq_wb_pkg;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'b00,
    MODE_REP   = 2'b01,
    MODE_REPE  = 2'b10,
    MODE_REPNE = 2'b11
  } rep_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } rep_state_e;

  localparam int unsigned OF_BIT = 11;
  localparam int unsigned DF_BIT = 10;
  localparam int unsigned SF_BIT = 7;
  localparam int unsigned ZF_BIT = 6;
  localparam int unsigned AF_BIT = 4;
  localparam int unsigned PF_BIT = 2;
  localparam int unsigned CF_BIT = 0;

  localparam logic [31:0] FLAGS_RST_DEF = 32'h0000_0002;
  localparam logic [31:0] POP_MASK_DEF  = 32'h0025_7FD5;

  // Maps flags_affected bit position {OF,DF,SF,ZF,AF,PF,CF} to its EFLAGS index.
  function automatic int unsigned flag_bit(input int unsigned sel);
    case (sel)
      6:       flag_bit = OF_BIT;
      5:       flag_bit = DF_BIT;
      4:       flag_bit = SF_BIT;
      3:       flag_bit = ZF_BIT;
      2:       flag_bit = AF_BIT;
      1:       flag_bit = PF_BIT;
      default: flag_bit = CF_BIT;
    endcase
  endfunction

endpackage

// File: rtl/rep_flags_seq_wb_flags.sv
// EFLAGS register: POPF merge, per-flag ALU update and the combinational bypass.
module flags_reg_wb
  import rep_flags_seq_wb_pkg::*;
#(
  parameter int unsigned       FLAG_W    = 32,
  parameter logic [FLAG_W-1:0] FLAGS_RST = FLAGS_RST_DEF,
  parameter logic [FLAG_W-1:0] POP_MASK  = POP_MASK_DEF
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              wb_v,
  input  logic              ld_flags,
  input  logic              pop_flags,
  input  logic [6:0]        flags_affected,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [FLAG_W-1:0] pop_value,
  output logic [FLAG_W-1:0] flags_q,
  output logic [FLAG_W-1:0] flags_next
);

  logic [FLAG_W-1:0] alu_merge;

  always_comb begin
    alu_merge = flags_q;
    for (int unsigned i = 0; i < 7; i++) begin
      if (flags_affected[i]) alu_merge[flag_bit(i)] = alu_flags[flag_bit(i)];
    end

    flags_next = flags_q;
    if (wb_v) begin
      if (pop_flags)     flags_next = (pop_value & POP_MASK) | (flags_q & ~POP_MASK);
      else if (ld_flags) flags_next = alu_merge;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) flags_q <= FLAGS_RST;
    else     flags_q <= flags_next;
  end

endmodule

// File: rtl/rep_flags_seq_wb.sv
// Writeback-stage REP/REPE/REPNE sequencer: ECX decrement, termination and redirect pulses.
module rep_flags_seq_wb
  import rep_flags_seq_wb_pkg::*;
#(
  parameter int unsigned       CNT_W     = 32,
  parameter int unsigned       FLAG_W    = 32,
  parameter logic [FLAG_W-1:0] FLAGS_RST = FLAGS_RST_DEF,
  parameter logic [FLAG_W-1:0] POP_MASK  = POP_MASK_DEF,
  parameter int unsigned       ITER_W    = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              wb_v,
  input  logic              wb_flush,
  input  logic [1:0]        rep_mode,
  input  logic              rep_start,
  input  logic              iter_end,
  input  logic              addr16,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              int_pending,
  input  logic              ld_flags,
  input  logic              pop_flags,
  input  logic [6:0]        flags_affected,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [FLAG_W-1:0] pop_value,
  output logic [FLAG_W-1:0] flags_q,
  output logic [FLAG_W-1:0] flags_next,
  output logic [CNT_W-1:0]  count_out,
  output logic              ld_count,
  output logic              rep_active,
  output logic              rep_redirect,
  output logic              rep_done,
  output logic              rep_skip,
  output logic              rep_int,
  output logic [ITER_W-1:0] iter_count
);

  flags_reg_wb #(
    .FLAG_W   (FLAG_W),
    .FLAGS_RST(FLAGS_RST),
    .POP_MASK (POP_MASK)
  ) u_flags (
    .CLK           (CLK),
    .CLR           (CLR),
    .wb_v          (wb_v),
    .ld_flags      (ld_flags),
    .pop_flags     (pop_flags),
    .flags_affected(flags_affected),
    .alu_flags     (alu_flags),
    .pop_value     (pop_value),
    .flags_q       (flags_q),
    .flags_next    (flags_next)
  );

  rep_mode_e   mode;
  rep_state_e  state_q, state_d;
  logic        redirect_q, redirect_d, done_q, done_d, skip_q, skip_d, int_q, int_d;
  logic [ITER_W-1:0] iter_q, iter_d, iter_base;
  logic [15:0]       low_dec;
  logic [CNT_W-1:0]  dec;
  logic go, start_hit, cnt_zero, dec_zero, eff_active, iter_hit, zf, term;

  assign mode = rep_mode_e'(rep_mode);
  assign zf   = flags_next[ZF_BIT];

  always_comb begin
    low_dec  = count_in[15:0] - 16'd1;
    dec      = addr16 ? {count_in[CNT_W-1:16], low_dec} : count_in - CNT_W'(1);
    cnt_zero = addr16 ? (count_in[15:0] == '0) : (count_in == '0);
    dec_zero = addr16 ? (dec[15:0] == '0) : (dec == '0);
    term     = dec_zero || (mode == MODE_REPE && !zf) || (mode == MODE_REPNE && zf);

    go         = wb_v && !wb_flush && (mode != MODE_NONE);
    start_hit  = go && rep_start && (state_q == ST_IDLE);
    // A single-uop string op starting with nonzero count runs its iteration as if already ACTIVE.
    eff_active = (state_q == ST_ACTIVE) || (start_hit && !cnt_zero);
    iter_hit   = go && iter_end && eff_active;

    ld_count  = iter_hit;
    count_out = iter_hit ? dec : '0;

    state_d    = state_q;
    iter_d     = iter_q;
    redirect_d = 1'b0;
    done_d     = 1'b0;
    skip_d     = 1'b0;
    int_d      = 1'b0;
    iter_base  = iter_q;

    if (wb_flush) begin
      state_d = ST_IDLE;
    end else if (start_hit) begin
      if (cnt_zero) begin
        skip_d = 1'b1;
      end else begin
        state_d   = ST_ACTIVE;
        iter_d    = '0;
        iter_base = '0;
      end
    end

    if (iter_hit) begin
      iter_d = (iter_base == '1) ? iter_base : iter_base + ITER_W'(1);
      if (term) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else if (int_pending) begin
        int_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        redirect_d = 1'b1;
        state_d    = ST_ACTIVE;
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      iter_q     <= '0;
      redirect_q <= 1'b0;
      done_q     <= 1'b0;
      skip_q     <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      redirect_q <= redirect_d;
      done_q     <= done_d;
      skip_q     <= skip_d;
      int_q      <= int_d;
    end
  end

  assign rep_active   = (state_q == ST_ACTIVE);
  assign rep_redirect = redirect_q;
  assign rep_done     = done_q;
  assign rep_skip     = skip_q;
  assign rep_int      = int_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_rep_flags_seq_wb.sv
// Directed checks of the REP writeback sequencer and EFLAGS register.
module tb_rep_flags_seq_wb;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        wb_v, wb_flush, rep_start, iter_end, addr16, int_pending;
  logic        ld_flags, pop_flags;
  logic [1:0]  rep_mode;
  logic [6:0]  flags_affected;
  logic [31:0] count_in, alu_flags, pop_value;
  logic [31:0] flags_q, flags_next, count_out;
  logic        ld_count, rep_active, rep_redirect, rep_done, rep_skip, rep_int;
  logic [15:0] iter_count;

  int total = 0;
  int bad   = 0;

  rep_flags_seq_wb #(
    .CNT_W (32),
    .FLAG_W(32),
    .ITER_W(16)
  ) dut (
    .CLK           (CLK),
    .CLR           (CLR),
    .wb_v          (wb_v),
    .wb_flush      (wb_flush),
    .rep_mode      (rep_mode),
    .rep_start     (rep_start),
    .iter_end      (iter_end),
    .addr16        (addr16),
    .count_in      (count_in),
    .int_pending   (int_pending),
    .ld_flags      (ld_flags),
    .pop_flags     (pop_flags),
    .flags_affected(flags_affected),
    .alu_flags     (alu_flags),
    .pop_value     (pop_value),
    .flags_q       (flags_q),
    .flags_next    (flags_next),
    .count_out     (count_out),
    .ld_count      (ld_count),
    .rep_active    (rep_active),
    .rep_redirect  (rep_redirect),
    .rep_done      (rep_done),
    .rep_skip      (rep_skip),
    .rep_int       (rep_int),
    .iter_count    (iter_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    wb_v = 0; wb_flush = 0; rep_start = 0; iter_end = 0; int_pending = 0;
    ld_flags = 0; pop_flags = 0; flags_affected = '0; alu_flags = '0; pop_value = '0;
  endtask

  task automatic pulses(input string tag, input logic [3:0] exp);
    check(tag, 32'({rep_redirect, rep_done, rep_skip, rep_int}), 32'(exp));
  endtask

  initial begin
    CLR = 1; quiet(); rep_mode = 2'b00; addr16 = 0; count_in = '0;
    tick(); tick();
    check("rst_flags", flags_q, 32'h2);
    pulses("rst_pulses", 4'b0000);
    check("rst_active", 32'(rep_active), 0);
    check("rst_iter", 32'(iter_count), 0);
    check("rst_ldcnt", 32'(ld_count), 0);
    check("rst_cnt", count_out, 0);
    CLR = 0; tick();

    // ALU flag update on ZF and CF only
    wb_v = 1; ld_flags = 1; flags_affected = 7'b0001001; alu_flags = 32'hFFF; #1;
    check("ld_bypass", flags_next, 32'h43);
    check("ld_notyet", flags_q, 32'h2);
    tick(); quiet();
    check("ld_flags", flags_q, 32'h43);

    // POPF beats a simultaneous ALU load
    wb_v = 1; pop_flags = 1; pop_value = 32'hFFFF_FFFF; ld_flags = 1; flags_affected = 7'h7F;
    tick(); quiet();
    check("popf", flags_q, 32'h0025_7FD7);

    // REP with zero count skips
    rep_mode = 2'b01; count_in = 0; wb_v = 1; rep_start = 1; #1;
    check("skip_ldcnt", 32'(ld_count), 0);
    tick(); quiet();
    pulses("skip_pulse", 4'b0010);
    check("skip_active", 32'(rep_active), 0);
    tick();
    pulses("skip_clear", 4'b0000);

    // mode 00 ignores start
    rep_mode = 2'b00; count_in = 5; wb_v = 1; rep_start = 1;
    tick(); quiet();
    check("none_active", 32'(rep_active), 0);
    pulses("none_pulse", 4'b0000);

    // REPNE, count 3, ZF cleared then set
    rep_mode = 2'b11; count_in = 3; wb_v = 1; rep_start = 1;
    tick(); quiet();
    check("repne_active", 32'(rep_active), 1);
    check("repne_iter0", 32'(iter_count), 0);
    wb_v = 1; iter_end = 1; ld_flags = 1; flags_affected = 7'b0001000; alu_flags = 32'h0; #1;
    check("repne_ld1", 32'(ld_count), 1);
    check("repne_cnt1", count_out, 2);
    tick(); quiet();
    pulses("repne_redir", 4'b1000);
    check("repne_iter1", 32'(iter_count), 1);
    check("repne_zf0", flags_q, 32'h0025_7F97);
    count_in = 2; wb_v = 1; iter_end = 1; ld_flags = 1; flags_affected = 7'b0001000; alu_flags = 32'h40; #1;
    check("repne_cnt2", count_out, 1);
    check("repne_zfnext", 32'(flags_next[6]), 1);
    tick(); quiet();
    pulses("repne_done", 4'b0100);
    check("repne_idle", 32'(rep_active), 0);
    check("repne_iter2", 32'(iter_count), 2);

    // REP with 16-bit address size: low half reaches zero
    rep_mode = 2'b01; addr16 = 1; count_in = 32'h0001_0001; wb_v = 1; rep_start = 1;
    tick(); quiet();
    check("a16_active", 32'(rep_active), 1);
    wb_v = 1; iter_end = 1; #1;
    check("a16_cnt", count_out, 32'h0001_0000);
    tick(); quiet();
    pulses("a16_done", 4'b0100);
    addr16 = 0;

    // single-uop start+iter_end, count 5
    count_in = 5; wb_v = 1; rep_start = 1; iter_end = 1; #1;
    check("single_ld", 32'(ld_count), 1);
    check("single_cnt", count_out, 4);
    tick(); quiet();
    pulses("single_redir", 4'b1000);
    check("single_iter", 32'(iter_count), 1);

    // 32-bit wrap mid-instruction
    count_in = 0; wb_v = 1; iter_end = 1; #1;
    check("wrap_cnt", count_out, 32'hFFFF_FFFF);
    tick(); quiet();
    pulses("wrap_redir", 4'b1000);
    check("wrap_active", 32'(rep_active), 1);

    // interrupt suspension
    count_in = 7; wb_v = 1; iter_end = 1; int_pending = 1; #1;
    check("int_ld", 32'(ld_count), 1);
    check("int_cnt", count_out, 6);
    tick(); quiet();
    pulses("int_pulse", 4'b0001);
    check("int_idle", 32'(rep_active), 0);

    // flush beats iter_end
    count_in = 4; wb_v = 1; rep_start = 1;
    tick(); quiet();
    wb_v = 1; iter_end = 1; wb_flush = 1; #1;
    check("flush_ld", 32'(ld_count), 0);
    tick(); quiet();
    pulses("flush_pulse", 4'b0000);
    check("flush_idle", 32'(rep_active), 0);

    // CLR mid-ACTIVE cancels pending pulse
    count_in = 9; wb_v = 1; rep_start = 1;
    tick(); quiet();
    check("clr_pre", 32'(rep_active), 1);
    wb_v = 1; iter_end = 1; #1;
    CLR = 1; #1;
    check("clr_idle", 32'(rep_active), 0);
    check("clr_flags", flags_q, 32'h2);
    tick(); quiet();
    pulses("clr_pulse", 4'b0000);
    check("clr_iter", 32'(iter_count), 0);
    CLR = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rep_flags_seq_wb.md
Name: rep_flags_seq_wb

Overview:
- Writeback-stage sequencer for REP/REPE/REPNE string instructions, combined with the architectural EFLAGS register.
- Generalises the fixed REPNE/CMPS termination logic and the 7-bit flags update with parametrised count width, selectable repeat mode, 16-bit address-size counting, interrupt suspension and pipeline flush.
- Sits after the EX/WB latch.
- Drives the ECX writeback, the front-end redirect (re-execute or fall through) and the current flags seen by conditional logic.

Parameters:
- CNT_W, 32, width of the count register path (ECX).
- FLAG_W, 32, width of the EFLAGS register.
- FLAGS_RST, 32'h0000_0002, EFLAGS reset value (bit 1 reserved-one).
- POP_MASK, 32'h00257FD5, bits of EFLAGS writable by POPF.
- ITER_W, 16, width of the saturating per-instruction iteration counter.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  asynchronous, active-high reset (1 = reset).
- wb_v  in  1  writeback uop valid.
- wb_flush  in  1  squash; sequencer returns to IDLE.
- rep_mode  in  2  00 none, 01 REP, 10 REPE, 11 REPNE.
- rep_start  in  1  first uop of a repeated instruction.
- iter_end  in  1  last uop of one iteration.
- addr16  in  1  count uses low 16 bits only.
- count_in  in  CNT_W  current ECX.
- int_pending  in  1  external interrupt waiting.
- ld_flags  in  1  flags update this uop.
- pop_flags  in  1  POPF this uop.
- flags_affected  in  7  per-flag enable: {OF,DF,SF,ZF,AF,PF,CF}.
- alu_flags  in  FLAG_W  ALU flag result.
- pop_value  in  FLAG_W  popped value.
- flags_q  out  FLAG_W  architectural EFLAGS.
- flags_next  out  FLAG_W  combinational next-flags (bypass).
- count_out  out  CNT_W  decremented count.
- ld_count  out  1  write count_out to ECX this cycle.
- rep_active  out  1  state is ACTIVE.
- rep_redirect  out  1  pulse: refetch same instruction.
- rep_done  out  1  pulse: fall through to next EIP.
- rep_skip  out  1  pulse: count was zero at start.
- rep_int  out  1  pulse: suspended for interrupt.
- iter_count  out  ITER_W  iterations of current instruction, saturating.

Behaviour:
- Reset (async, immediate on CLR=1):
  - flags_q = FLAGS_RST; state = IDLE; iter_count = 0.
  - All pulses and ld_count = 0; count_out = 0.
- Flags (gated by wb_v):
  - pop_flags=1: next = (pop_value & POP_MASK) | (flags_q & ~POP_MASK). pop_flags has priority over ld_flags.
  - Else if ld_flags=1: bits 11,10,7,6,4,2,0 take alu_flags where flags_affected[6..0] is set; all other bits hold.
  - flags_next is combinational. flags_q loads it at the edge, so the update is visible the next cycle.
  - wb_flush does not block a valid uop's flag update in the same cycle.
- Count arithmetic:
  - addr16=1: dec = {count_in[CNT_W-1:16], count_in[15:0]-1}; zero test on [15:0] only.
  - addr16=0: full-width decrement, wrapping modulo 2^CNT_W; zero test on all bits.
- ld_count = wb_v & iter_end & mode!=0 & state==ACTIVE & !wb_flush. Combinational, same cycle; count_out = dec.
- Termination condition T is evaluated on dec and on flags_next ZF:
  - (dec==0), or
  - REPE and ZF=0, or
  - REPNE and ZF=1.
- FSM (IDLE, ACTIVE). All transitions require wb_v & !wb_flush. Pulses are registered: asserted exactly one cycle after the triggering writeback.
  - IDLE, rep_start, mode!=0, count zero: rep_skip; stay IDLE.
  - IDLE, rep_start, mode!=0, count nonzero: go ACTIVE; iter_count = 0.
  - ACTIVE, iter_end, T: rep_done; go IDLE.
  - ACTIVE, iter_end, !T, int_pending: rep_int; go IDLE. ECX is still written, so the instruction resumes correctly.
  - ACTIVE, iter_end, !T, !int_pending: rep_redirect; stay ACTIVE.
  - Every iter_end in ACTIVE increments iter_count, saturating at all-ones.
- rep_start with iter_end in the same uop (single-uop string op):
  - Start is evaluated first.
  - If count is nonzero, the iter_end is applied in the same cycle with IDLE treated as ACTIVE.
- Flush and reset:
  - wb_flush=1 forces IDLE next cycle, with no pulses and no ld_count. Flush beats a simultaneous start or iter_end.
  - CLR mid-iteration: any pending pulse is cancelled.
- mode=00: the FSM ignores rep_start and iter_end.

Decomposition:
- Shared package:
  - rep_mode encodings.
  - Flag bit indices (OF=11, DF=10, SF=7, ZF=6, AF=4, PF=2, CF=0).
  - FLAGS_RST and POP_MASK defaults.
  - State encoding.
- Sub-module flags_reg_wb: the merge, POP and register path, instantiated once.
- FSM, count arithmetic and pulses live in the top module.

Test Plan:
- Flags and reset:
  - Reset -> flags_q=0x2, all pulses 0.
  - ld_flags, affected=7'b0001001, alu_flags=0xFFF -> flags_q=0x043 next cycle.
  - pop_flags, pop_value=0xFFFFFFFF from 0x2 -> flags_q=0x00257FD7.
- REP zero count: REP, count_in=0, rep_start -> rep_skip one cycle later; ld_count never asserted; rep_active stays 0.
- REPNE with ZF termination:
  - count 3, iter_end with ZF=0 -> count_out=2, rep_redirect.
  - iter_end with ZF=1 (ld_flags) -> count_out=1, rep_done, IDLE, iter_count=2.
- REP with addr16: count_in=0x0001_0001, iter_end -> count_out=0x0001_0000, rep_done (low half zero).
- REP with 32-bit wrap: count_in=0, addr16=0, mid-instruction -> count_out=0xFFFFFFFF, no termination.
- Interrupt and flush:
  - ACTIVE, int_pending=1, !T -> rep_int, ld_count=1, IDLE.
  - wb_flush together with iter_end -> no pulse, no ld_count, IDLE.
  - CLR asserted mid-ACTIVE -> immediate IDLE.
